// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives the req/gnt/rvalid
// port to instruction memory and fills IF/ID through a one-entry skid buffer.
package core_pkg;
    typedef enum logic [1:0] {
        NEXTPC     = 2'd0,
        ALU_RESULT = 2'd1,
        NOP_PC_MUX = 2'd2
    } pc_mux_t;
endpackage

module fetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic        instr_req_op,
    output logic [31:0] instr_addr_op,
    input  logic        instr_gnt_ip,
    input  logic        instr_rvalid_ip,
    input  logic [31:0] instr_rdata_ip,
    input  logic        stall_ip,
    input  logic        flush_en_ip,
    input  pc_mux_t     pc_mux_ip,
    input  logic [31:0] pc_branch_target_ip,
    output logic [31:0] pc_op,
    output logic [31:0] pc4_op,
    output logic        instr_data_valid_op,
    output logic [31:0] instr_data_op
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic        drop;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        redirect;
    logic        kill;
    logic        deliver;
    logic        take_if;
    logic        skid_hold;
    logic        skid_next;
    logic        granted;
    logic        outstanding;
    logic [31:0] fetch_pc4;
    logic [31:0] target;

    always_comb begin
        redirect  = (pc_mux_ip == ALU_RESULT);
        kill      = redirect || flush_en_ip;
        target    = pc_branch_target_ip & 32'hFFFF_FFFC;
        fetch_pc4 = fetch_pc + 32'd4;
        deliver   = (state == WAIT) && instr_rvalid_ip && !drop && !kill;
        take_if   = !stall_ip || !instr_data_valid_op;
        skid_hold = skid_valid && !take_if;
        if (kill)
            skid_next = 1'b0;
        else if (take_if)
            skid_next = skid_valid && deliver;
        else
            skid_next = skid_valid || deliver;

        instr_req_op  = 1'b0;
        instr_addr_op = fetch_pc;
        unique case (state)
            REQ: begin
                // Old response still in flight after reset: wait it out
                instr_req_op = !reset && !drop && !skid_hold;
            end
            WAIT: begin
                instr_req_op  = !reset && deliver && !skid_next;
                instr_addr_op = fetch_pc4;
            end
            default: ;
        endcase

        granted     = instr_req_op && instr_gnt_ip;
        outstanding = ((state == WAIT) && !instr_rvalid_ip) || granted;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state               <= IDLE;
            fetch_pc            <= BOOT_ADDR;
            // Remember a grant that is still in flight across reset
            drop                <= (drop || state == WAIT) && !instr_rvalid_ip;
            skid_valid          <= 1'b0;
            skid_pc             <= 32'd0;
            skid_instr          <= 32'd0;
            pc_op               <= 32'd0;
            pc4_op              <= 32'd0;
            instr_data_op       <= 32'd0;
            instr_data_valid_op <= 1'b0;
        end else begin
            unique case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (granted)
                        state <= WAIT;
                end
                WAIT: begin
                    if (instr_rvalid_ip && !granted)
                        state <= REQ;
                end
                default: state <= IDLE;
            endcase

            if (kill && outstanding)
                drop <= 1'b1;
            else if (instr_rvalid_ip)
                drop <= 1'b0;

            if (redirect)
                fetch_pc <= target;
            else if (deliver)
                fetch_pc <= fetch_pc4;

            if (kill) begin
                instr_data_valid_op <= 1'b0;
            end else if (take_if) begin
                if (skid_valid) begin
                    pc_op               <= skid_pc;
                    pc4_op              <= skid_pc + 32'd4;
                    instr_data_op       <= skid_instr;
                    instr_data_valid_op <= 1'b1;
                end else if (deliver) begin
                    pc_op               <= fetch_pc;
                    pc4_op              <= fetch_pc4;
                    instr_data_op       <= instr_rdata_ip;
                    instr_data_valid_op <= 1'b1;
                end else begin
                    instr_data_valid_op <= 1'b0;
                end
            end

            skid_valid <= skid_next;
            if (deliver && (skid_valid || !take_if)) begin
                skid_pc    <= fetch_pc;
                skid_instr <= instr_rdata_ip;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage against a small req/gnt/rvalid
// memory whose data word is the bitwise inverse of its address.
module tb_fetch_stage;
    import core_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    pc_mux_t     pc_mux = NEXTPC;
    logic [31:0] target = 32'd0;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] instr;

    logic        gnt_en = 1'b1;
    int          lat = 0;
    logic        pend = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          dly = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fetch_stage #(.BOOT_ADDR(32'h0000_0100)) dut (
        .clock               (clock),
        .reset               (reset),
        .instr_req_op        (instr_req),
        .instr_addr_op       (instr_addr),
        .instr_gnt_ip        (instr_gnt),
        .instr_rvalid_ip     (instr_rvalid),
        .instr_rdata_ip      (instr_rdata),
        .stall_ip            (stall),
        .flush_en_ip         (flush),
        .pc_mux_ip           (pc_mux),
        .pc_branch_target_ip (target),
        .pc_op               (pc),
        .pc4_op              (pc4),
        .instr_data_valid_op (valid),
        .instr_data_op       (instr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic exp_if(input string tag, input logic v,
                          input logic [31:0] p, input logic [31:0] p4);
        chk({tag, "_v"}, {31'd0, valid}, {31'd0, v});
        if (v) begin
            chk({tag, "_pc"}, pc, p);
            chk({tag, "_pc4"}, pc4, p4);
            chk({tag, "_ins"}, instr, ~p);
        end
    endtask

    task automatic exp_req(input string tag, input logic r,
                           input logic [31:0] a);
        chk({tag, "_req"}, {31'd0, instr_req}, {31'd0, r});
        if (r)
            chk({tag, "_addr"}, instr_addr, a);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    assign instr_gnt    = instr_req & gnt_en;
    assign instr_rvalid = pend && (dly == 0);
    assign instr_rdata  = ~paddr;

    always @(posedge clock) begin
        if (instr_req && instr_gnt)
            chk("one_outst", {31'd0, pend && !instr_rvalid}, 32'd0);
        if (instr_rvalid)
            pend <= 1'b0;
        else if (pend && dly > 0)
            dly <= dly - 1;
        if (instr_req && instr_gnt) begin
            pend  <= 1'b1;
            paddr <= instr_addr;
            dly   <= lat;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_v", {31'd0, valid}, 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_pc4", pc4, 32'd0);
        chk("rst_ins", instr, 32'd0);
        exp_req("idle", 1'b0, 32'd0);
        step(); #1; exp_req("boot0", 1'b1, 32'h100); exp_if("boot0", 1'b0, 0, 0);
        step(); #1; exp_req("boot1", 1'b1, 32'h104);
        step(); #1; exp_req("boot2", 1'b1, 32'h108);
        exp_if("boot2", 1'b1, 32'h100, 32'h104);
        // stall three cycles with 0x104 in IF/ID
        step(); stall = 1'b1; #1;
        exp_if("stall0", 1'b1, 32'h104, 32'h108); exp_req("stall0", 1'b0, 0);
        step(); #1; exp_if("stall1", 1'b1, 32'h104, 32'h108); exp_req("stall1", 1'b0, 0);
        step(); #1; exp_if("stall2", 1'b1, 32'h104, 32'h108); exp_req("stall2", 1'b0, 0);
        step(); stall = 1'b0; #1;
        exp_if("rel0", 1'b1, 32'h104, 32'h108); exp_req("rel0", 1'b1, 32'h10C);
        step(); #1; exp_if("rel1", 1'b1, 32'h108, 32'h10C); exp_req("rel1", 1'b1, 32'h110);
        step(); #1; exp_if("rel2", 1'b1, 32'h10C, 32'h110);
        step(); reset = 1'b1; #1; exp_req("rst_req", 1'b0, 0);
        step();
        step(); reset = 1'b0; #1; exp_if("rstb", 1'b0, 0, 0);
        step(); step(); step(); #1; exp_if("b3", 1'b1, 32'h100, 32'h104);
        // 0x10C granted with slow response, then redirect to 0x200
        step(); lat = 3; #1;
        exp_if("b4", 1'b1, 32'h104, 32'h108); exp_req("b4", 1'b1, 32'h10C);
        step(); lat = 0; pc_mux = ALU_RESULT; target = 32'h200; #1;
        exp_if("br0", 1'b1, 32'h108, 32'h10C); exp_req("br0", 1'b0, 0);
        step(); pc_mux = NEXTPC; #1; exp_if("br1", 1'b0, 0, 0); exp_req("br1", 1'b0, 0);
        step(); #1; exp_if("br2", 1'b0, 0, 0); exp_req("br2", 1'b0, 0);
        step(); #1; exp_if("br_drop", 1'b0, 0, 0); exp_req("br_drop", 1'b0, 0);
        step(); #1; exp_if("br_nod", 1'b0, 0, 0); exp_req("br_tgt", 1'b1, 32'h200);
        step(); #1; exp_req("br_tgt4", 1'b1, 32'h204);
        step(); #1; exp_if("br_pc0", 1'b1, 32'h200, 32'h204);
        // fill skid, then flush and stall together
        step(); stall = 1'b1; #1;
        exp_if("br_pc1", 1'b1, 32'h204, 32'h208); exp_req("skid_full", 1'b0, 0);
        step(); flush = 1'b1; #1;
        exp_if("fl0", 1'b1, 32'h204, 32'h208); exp_req("fl0", 1'b0, 0);
        step(); stall = 1'b0; flush = 1'b0; #1;
        exp_if("fl1", 1'b0, 0, 0); exp_req("fl_refetch", 1'b1, 32'h20C);
        step(); #1; exp_if("fl2", 1'b0, 0, 0);
        // redirect to the top of the address space
        step(); pc_mux = ALU_RESULT; target = 32'hFFFF_FFFC; #1;
        exp_if("fl3", 1'b1, 32'h20C, 32'h210); exp_req("wrap_kill", 1'b0, 0);
        step(); pc_mux = NEXTPC; #1;
        exp_if("wrap0", 1'b0, 0, 0); exp_req("wrap0", 1'b1, 32'hFFFF_FFFC);
        step(); #1; exp_req("wrap_addr", 1'b1, 32'h0);
        step(); #1; exp_if("wrap_pc", 1'b1, 32'hFFFF_FFFC, 32'h0);
        step(); lat = 3; #1;
        exp_if("wrap_pc1", 1'b1, 32'h0, 32'h4); exp_req("wrap_pc1", 1'b1, 32'h8);
        // reset while 0x8 is in flight; its response lands after reset
        step(); reset = 1'b1; lat = 0; #1; exp_req("rstw", 1'b0, 0);
        step();
        step(); reset = 1'b0; #1;
        exp_if("rste", 1'b0, 0, 0); chk("rste_pc", pc, 32'd0);
        step(); #1; exp_req("stale_rv", 1'b0, 0); exp_if("stale_rv", 1'b0, 0, 0);
        step(); #1; exp_req("boot_again", 1'b1, 32'h100);
        step(); #1; exp_if("stale1", 1'b0, 0, 0);
        step(); #1; exp_if("stale_drop", 1'b1, 32'h100, 32'h104);
        step(); #1; exp_if("after", 1'b1, 32'h104, 32'h108);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction Fetch stage of the 5-stage RISCV core.
- Owns the fetch PC and issues word requests to instruction memory over a req/gnt/rvalid handshake.
- Drives the IF/ID pipeline register that feeds decode: pc, pc4, instruction and its valid bit.
- Consumes decode's stall, the flush controller's flush, and the PC redirect (pc_mux, branch target) produced in ID/EX.

Parameters:
BOOT_ADDR, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clock  input  1  core clock
reset  input  1  synchronous, active-high reset
instr_req_op  output  1  fetch request to instruction memory
instr_addr_op  output  32  fetch address, word aligned
instr_gnt_ip  input  1  memory accepted the request this cycle
instr_rvalid_ip  input  1  read data valid (response to the oldest granted request)
instr_rdata_ip  input  32  fetched instruction word
stall_ip  input  1  decode stall; hold IF/ID register
flush_en_ip  input  1  flush IF/ID contents and any pending fetch
pc_mux_ip  input  pc_mux (CORE_PKG)  NEXTPC / ALU_RESULT / NOP_PC_MUX
pc_branch_target_ip  input  32  redirect target, used when pc_mux_ip==ALU_RESULT
pc_op  output  32  PC of the instruction in IF/ID
pc4_op  output  32  pc_op+4, mod 2^32
instr_data_valid_op  output  1  IF/ID instruction valid
instr_data_op  output  32  IF/ID instruction

Behaviour:
- Clock and reset: single clock, edge-triggered; reset is synchronous and active-high.
- Reset values:
  - fetch_pc = BOOT_ADDR.
  - instr_req_op = 0; pc_op, pc4_op, instr_data_op = 0; instr_data_valid_op = 0.
  - Skid buffer empty, drop flag clear, FSM = IDLE.
- At most one granted-but-unreturned request at any time.
- FSM states:
  - IDLE: entered only via reset; go to REQ on the first cycle reset is low. No request is issued in IDLE.
  - REQ:
    - instr_req_op=1, instr_addr_op=fetch_pc.
    - Memory samples the address only in the gnt cycle, so a redirect before grant simply changes instr_addr_op.
    - gnt -> WAIT.
    - REQ is held (instr_req_op=0) while the skid buffer is full.
  - WAIT:
    - instr_req_op=0 unless rvalid is present this cycle.
    - On rvalid with drop flag set: discard the data, clear the flag, go to REQ (fetch_pc already holds the redirect target).
    - On rvalid with drop flag clear:
      - Deliver {fetch_pc, rdata} and set fetch_pc += 4.
      - If the skid buffer will be empty after this cycle, issue the next request combinationally in the same cycle (instr_req_op=1, addr=fetch_pc+4). Gnt -> stay in WAIT; no gnt -> REQ.
      - Otherwise -> REQ (held).
- Throughput: with zero-wait memory (gnt same cycle, rvalid next cycle), one instruction per cycle.
- Latency: instruction is visible on IF/ID outputs the cycle after rvalid.
- Delivery into IF/ID:
  - If stall_ip=0, or IF/ID is invalid: load IF/ID (valid=1).
  - Else load the one-entry skid buffer.
  - When stall_ip=0 and the skid buffer is full: skid moves to IF/ID in that cycle. A simultaneous rvalid goes to the skid buffer, so the buffer stays full.
  - Program order is always preserved; no duplication, no loss.
- While stall_ip=1 and flush_en_ip=0: pc_op, pc4_op, instr_data_op and instr_data_valid_op hold their values.
- Flush (flush_en_ip=1):
  - Next cycle instr_data_valid_op=0; skid buffer cleared.
  - Outstanding granted request -> set drop flag.
  - Flush has priority over stall, and over delivery in the same cycle.
- Redirect (pc_mux_ip==ALU_RESULT):
  - fetch_pc <= pc_branch_target_ip.
  - Request granted this or an earlier cycle and not yet returned -> set drop flag.
  - Redirect without flush_en_ip still discards younger fetched instructions (IF/ID and skid buffer).
- NEXTPC and NOP_PC_MUX: no effect on fetch_pc.
- Arithmetic: fetch_pc and pc4_op wrap modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000). The low two address bits are always 0.
- Reset mid-transaction: state returns to reset values, and any rvalid arriving after reset deassertion that belongs to the pre-reset request is ignored (drop flag set on reset exit if a grant was pending).

Test Plan:
- BOOT_ADDR=0x100, zero-wait memory, reset low at cycle 0 -> instr_addr_op 0x100,0x104,0x108 on consecutive cycles; pc_op 0x100,0x104,0x108 with valid=1, pc4_op=pc_op+4.
- stall_ip=1 for 3 cycles while pc_op=0x104 -> outputs hold 0x104; 0x108 lands in the skid buffer; no req while skid full; after release pc_op 0x108, 0x10C with no gap or duplicate.
- Redirect pc_mux_ip=ALU_RESULT, target 0x200, while 0x10C is granted and unreturned -> the 0x10C response is dropped; the next valid pc_op is 0x200, then 0x204.
- flush_en_ip=1 and stall_ip=1 in the same cycle with a valid IF/ID and a full skid buffer -> instr_data_valid_op=0 next cycle; skid contents never appear.
- Redirect to 0xFFFF_FFFC -> pc_op 0xFFFF_FFFC, pc4_op 0x0; next fetch address 0x0.
- Reset asserted in WAIT, rvalid arrives the cycle after reset deasserts -> data discarded; first delivered pc_op=BOOT_ADDR.
